// File: rtl/bin_to_bcd7seg_display.sv
// Binary to DIGITS-digit decimal converter (sequential double-dabble, one shift per clock)
// driving active-low 7-segment displays with optional leading-zero blanking and overflow dashes.
module bin_to_bcd7seg_display #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int BLANK_LZ = 1
) (
   input  logic                  Clock,
   input  logic                  Resetn,
   input  logic                  Load,
   input  logic [WIDTH-1:0]      Bin,
   output logic [7*DIGITS-1:0]   HEX,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Overflow
);

   localparam int              BCD_W     = 4 * DIGITS;
   localparam int              CNT_W     = $clog2(WIDTH + 1);
   localparam logic [31:0]     MAX_VAL   = 32'(10**DIGITS - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
   localparam logic [6:0]      SEG_BLANK = 7'b1111111;
   localparam logic [6:0]      SEG_DASH  = 7'b1111110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_r, state_nx_s;
   logic [WIDTH-1:0]     bin_r, bin_nx_s;
   logic [BCD_W-1:0]     bcd_r, bcd_nx_s, bcd_adj_s;
   logic [CNT_W-1:0]     cnt_r, cnt_nx_s;
   logic                 ovf_pend_r, ovf_nx_s;
   logic                 update_s;
   logic [7*DIGITS-1:0]  hex_s, hex_r;
   logic                 busy_r, done_r, overflow_r;
   logic                 lz_s;
   logic [3:0]           nib_s;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0000100;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
         else                      r[4*i +: 4] = b[4*i +: 4];
      end
      return r;
   endfunction

   // Next-state and datapath for the IDLE/SHIFT/DONE sequencer.
   always_comb begin
      state_nx_s = state_r;
      bin_nx_s   = bin_r;
      bcd_nx_s   = bcd_r;
      cnt_nx_s   = cnt_r;
      ovf_nx_s   = ovf_pend_r;
      update_s   = 1'b0;
      bcd_adj_s  = add3(bcd_r);
      case (state_r)
         IDLE, DONE: begin
            if (Load) begin
               state_nx_s = SHIFT;
               bin_nx_s   = Bin;
               bcd_nx_s   = '0;
               cnt_nx_s   = '0;
               ovf_nx_s   = (32'(Bin) > MAX_VAL);
            end else begin
               state_nx_s = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_r == LAST_CNT) begin
               state_nx_s = DONE;
               update_s   = 1'b1;
            end else begin
               {bcd_nx_s, bin_nx_s} = {bcd_adj_s[BCD_W-2:0], bin_r, 1'b0};
               cnt_nx_s             = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Segment encoding of the finished BCD value, scanning from the top digit for blanking.
   always_comb begin
      hex_s = '1;
      lz_s  = 1'b1;
      nib_s = 4'd0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nib_s = bcd_r[4*i +: 4];
         lz_s  = lz_s & (nib_s == 4'd0);
         if (ovf_pend_r)                             hex_s[7*i +: 7] = SEG_DASH;
         else if ((BLANK_LZ != 0) && (i > 0) && lz_s) hex_s[7*i +: 7] = SEG_BLANK;
         else                                        hex_s[7*i +: 7] = seg7(nib_s);
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_r    <= IDLE;
         bin_r      <= '0;
         bcd_r      <= '0;
         cnt_r      <= '0;
         ovf_pend_r <= 1'b0;
         hex_r      <= '1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         bin_r      <= bin_nx_s;
         bcd_r      <= bcd_nx_s;
         cnt_r      <= cnt_nx_s;
         ovf_pend_r <= ovf_nx_s;
         busy_r     <= (state_nx_s == SHIFT);
         done_r     <= (state_nx_s == DONE);
         if (update_s) begin
            hex_r      <= hex_s;
            overflow_r <= ovf_pend_r;
         end
      end
   end

   assign HEX      = hex_r;
   assign Busy     = busy_r;
   assign Done     = done_r;
   assign Overflow = overflow_r;

endmodule

// File: tb/tb_bin_to_bcd7seg_display.sv
// Directed self-checking bench: three instances (blanking, no blanking, two digits)
// share one stimulus stream and are checked against hand-computed segment patterns.
module tb_bin_to_bcd7seg_display;

   localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                          S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                          S9 = 7'b0000100, BL = 7'b1111111, DA = 7'b1111110;

   logic        Clock, Resetn, Load;
   logic [7:0]  Bin;
   logic [20:0] hex_a, hex_b;
   logic [13:0] hex_c;
   logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b, busy_c, done_c, ovf_c;
   int          n_checks, n_fail;

   bin_to_bcd7seg_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) u_lz (
      .Clock(Clock), .Resetn(Resetn), .Load(Load), .Bin(Bin),
      .HEX(hex_a), .Busy(busy_a), .Done(done_a), .Overflow(ovf_a));
   bin_to_bcd7seg_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(0)) u_nolz (
      .Clock(Clock), .Resetn(Resetn), .Load(Load), .Bin(Bin),
      .HEX(hex_b), .Busy(busy_b), .Done(done_b), .Overflow(ovf_b));
   bin_to_bcd7seg_display #(.WIDTH(8), .DIGITS(2), .BLANK_LZ(1)) u_d2 (
      .Clock(Clock), .Resetn(Resetn), .Load(Load), .Bin(Bin),
      .HEX(hex_c), .Busy(busy_c), .Done(done_c), .Overflow(ovf_c));

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Load for one clock; returns at the falling edge after the accepting edge (edge 0).
   task automatic start_load(input logic [7:0] value);
      @(negedge Clock);
      Bin  = value;
      Load = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      Load = 1'b0;
   endtask

   // Bounded wait for Done on the main instance; cyc = edges after edge 0.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done_a && cyc < 20) begin
         @(negedge Clock);
         cyc++;
      end
   endtask

   task automatic test_reset();
      Resetn = 1'b1; Load = 1'b0; Bin = 8'd0;
      #3 Resetn = 1'b0;
      #1;
      n_checks++; if (hex_a !== 21'h1FFFFF) begin n_fail++; $display("FAIL reset_hex got=%h exp=%h", hex_a, 21'h1FFFFF); end
      n_checks++; if (hex_c !== 14'h3FFF) begin n_fail++; $display("FAIL reset_hex_d2 got=%h exp=%h", hex_c, 14'h3FFF); end
      n_checks++; if ({busy_a, done_a, ovf_a} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {busy_a, done_a, ovf_a}); end
      @(negedge Clock);
      Resetn = 1'b1;
   endtask

   task automatic test_max();
      int cyc;
      start_load(8'd255);
      for (int k = 0; k <= 8; k++) begin
         n_checks++; if ({busy_a, done_a} !== 2'b10) begin n_fail++; $display("FAIL max_busy k=%0d got=%b exp=10", k, {busy_a, done_a}); end
         n_checks++; if (hex_a !== 21'h1FFFFF) begin n_fail++; $display("FAIL max_hex_hold k=%0d got=%h exp=1fffff", k, hex_a); end
         @(negedge Clock);
      end
      n_checks++; if ({busy_a, done_a} !== 2'b01) begin n_fail++; $display("FAIL max_done got=%b exp=01", {busy_a, done_a}); end
      n_checks++; if (hex_a !== {S2, S5, S5}) begin n_fail++; $display("FAIL max_hex got=%b exp=%b", hex_a, {S2, S5, S5}); end
      n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL max_ovf got=%b exp=0", ovf_a); end
      n_checks++; if ({ovf_c, hex_c} !== {1'b1, DA, DA}) begin n_fail++; $display("FAIL max_d2 got=%b exp=%b", {ovf_c, hex_c}, {1'b1, DA, DA}); end
      @(negedge Clock);
      n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL max_done_pulse got=%b exp=0", done_a); end
      cyc = 0;
   endtask

   task automatic test_blanking();
      int cyc;
      start_load(8'd7);
      wait_done(cyc);
      n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL blank7_latency got=%0d exp=9", cyc); end
      n_checks++; if (hex_a !== {BL, BL, 7'b0001111}) begin n_fail++; $display("FAIL blank7_lz got=%b", hex_a); end
      n_checks++; if (hex_b !== {S0, S0, 7'b0001111}) begin n_fail++; $display("FAIL blank7_nolz got=%b", hex_b); end
      n_checks++; if (hex_c !== {BL, 7'b0001111}) begin n_fail++; $display("FAIL blank7_d2 got=%b", hex_c); end
      n_checks++; if (ovf_c !== 1'b0) begin n_fail++; $display("FAIL blank7_d2_ovf got=%b exp=0", ovf_c); end
      start_load(8'd0);
      wait_done(cyc);
      n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL zero_latency got=%0d exp=9", cyc); end
      n_checks++; if (hex_a !== {BL, BL, S0}) begin n_fail++; $display("FAIL zero_lz got=%b", hex_a); end
      n_checks++; if (hex_b !== {S0, S0, S0}) begin n_fail++; $display("FAIL zero_nolz got=%b", hex_b); end
      n_checks++; if (hex_c !== {BL, S0}) begin n_fail++; $display("FAIL zero_d2 got=%b", hex_c); end
   endtask

   task automatic test_overflow();
      int cyc;
      start_load(8'd100);
      wait_done(cyc);
      n_checks++; if ({ovf_c, hex_c} !== {1'b1, DA, DA}) begin n_fail++; $display("FAIL ovf100_d2 got=%b exp=%b", {ovf_c, hex_c}, {1'b1, DA, DA}); end
      n_checks++; if ({ovf_a, hex_a} !== {1'b0, S1, S0, S0}) begin n_fail++; $display("FAIL ovf100_d3 got=%b", {ovf_a, hex_a}); end
      repeat (3) @(negedge Clock);
      n_checks++; if (ovf_c !== 1'b1) begin n_fail++; $display("FAIL ovf_hold got=%b exp=1", ovf_c); end
      start_load(8'd99);
      n_checks++; if (ovf_c !== 1'b1) begin n_fail++; $display("FAIL ovf_hold_shift got=%b exp=1", ovf_c); end
      wait_done(cyc);
      n_checks++; if ({ovf_c, hex_c} !== {1'b0, S9, S9}) begin n_fail++; $display("FAIL ovf99_d2 got=%b exp=%b", {ovf_c, hex_c}, {1'b0, S9, S9}); end
      n_checks++; if (hex_a !== {BL, S9, S9}) begin n_fail++; $display("FAIL ovf99_d3 got=%b", hex_a); end
   endtask

   task automatic test_back_to_back();
      logic exp_done;
      @(negedge Clock);
      Bin  = 8'd12;
      Load = 1'b1;
      @(posedge Clock);
      for (int c = 0; c <= 20; c++) begin
         @(negedge Clock);
         if (c == 1) Bin = 8'd34;
         exp_done = (c == 9) || (c == 19);
         if (c <= 19) begin
            n_checks++; if ({busy_a, done_a} !== {~exp_done, exp_done}) begin n_fail++; $display("FAIL b2b_flags c=%0d got=%b exp=%b", c, {busy_a, done_a}, {~exp_done, exp_done}); end
         end else begin
            n_checks++; if ({busy_a, done_a} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle got=%b exp=00", {busy_a, done_a}); end
         end
         if (c >= 9 && c < 19) begin
            n_checks++; if (hex_a !== {BL, S1, S2}) begin n_fail++; $display("FAIL b2b_hex12 c=%0d got=%b", c, hex_a); end
         end
         if (c == 19) begin
            n_checks++; if (hex_a !== {BL, S3, S4}) begin n_fail++; $display("FAIL b2b_hex34 got=%b", hex_a); end
            Load = 1'b0;
         end
      end
   endtask

   task automatic test_reset_abort();
      int cyc;
      start_load(8'd200);
      repeat (4) @(negedge Clock);
      Resetn = 1'b0;
      #1;
      n_checks++; if (hex_a !== 21'h1FFFFF) begin n_fail++; $display("FAIL abort_hex got=%h exp=1fffff", hex_a); end
      n_checks++; if ({busy_a, done_a, ovf_a, busy_c, ovf_c} !== 5'b00000) begin n_fail++; $display("FAIL abort_flags got=%b exp=00000", {busy_a, done_a, ovf_a, busy_c, ovf_c}); end
      @(negedge Clock);
      Resetn = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge Clock);
         n_checks++; if ({busy_a, done_a} !== 2'b00) begin n_fail++; $display("FAIL abort_no_done c=%0d got=%b exp=00", c, {busy_a, done_a}); end
      end
      start_load(8'd42);
      wait_done(cyc);
      n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL abort42_latency got=%0d exp=9", cyc); end
      n_checks++; if (hex_a !== {BL, S4, S2}) begin n_fail++; $display("FAIL abort42_lz got=%b", hex_a); end
      n_checks++; if (hex_b !== {S0, S4, S2}) begin n_fail++; $display("FAIL abort42_nolz got=%b", hex_b); end
      n_checks++; if (hex_c !== {S4, S2}) begin n_fail++; $display("FAIL abort42_d2 got=%b", hex_c); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_max();
      test_blanking();
      test_overflow();
      test_back_to_back();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
